// File: rtl/weapon_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : weapon_bank_ctrl
// Brief    : N_CH independent weapon channels, each with a saturating ammo
//            counter, programmable capacity and a READY/COOLDOWN/RELOADING FSM.
//            Optional build macro: AUTO_RELOAD_EN (full refill on empty shot).
// Revision : 1.0 - initial release
// ============================================================================
module weapon_bank_ctrl #(
  parameter int         N_CH         = 2,
  parameter int         AMMO_W       = 9,
  parameter int         RATE_W       = 9,
  parameter int         DEF_CAP      = 500,
  parameter int         RELOAD_CYC   = 4,
  parameter int         COOLDOWN_CYC = 1,
  parameter logic [3:0] ATTACK_MODE  = 4'b0010
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               mode_sel,
  input  logic [N_CH-1:0]          cap_load,
  input  logic [AMMO_W-1:0]        cap_in,
  input  logic [N_CH*RATE_W-1:0]   rate_in,
  input  logic [N_CH-1:0]          fire,
  input  logic [N_CH-1:0]          reload_req,
  input  logic [AMMO_W-1:0]        reload_amt,
  output logic [N_CH*AMMO_W-1:0]   ammo_out,
  output logic [N_CH-1:0]          empty,
  output logic [N_CH-1:0]          busy,
  output logic [N_CH-1:0]          err
);

  localparam int T_MAX = (RELOAD_CYC > COOLDOWN_CYC) ? RELOAD_CYC : COOLDOWN_CYC;
  localparam int TMR_W = $clog2(T_MAX + 1);
  localparam int CMP_W = (AMMO_W > RATE_W) ? AMMO_W : RATE_W;

  localparam logic [AMMO_W-1:0] CAP_RST  = AMMO_W'(DEF_CAP);
  localparam logic [TMR_W-1:0]  T_RELOAD = TMR_W'(RELOAD_CYC);
  localparam logic [TMR_W-1:0]  T_COOL   = TMR_W'(COOLDOWN_CYC);
  localparam logic [TMR_W-1:0]  T_ONE    = TMR_W'(1);

  typedef enum logic [1:0] {
    ST_READY     = 2'd0,
    ST_COOLDOWN  = 2'd1,
    ST_RELOADING = 2'd2
  } state_t;

  logic mode_ok;
  assign mode_ok = (mode_sel == ATTACK_MODE);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t              state, state_nx;
    logic [AMMO_W-1:0]   ammo, ammo_nx;
    logic [AMMO_W-1:0]   cap, cap_nx;
    logic [AMMO_W-1:0]   amt, amt_nx;
    logic [TMR_W-1:0]    timer, timer_nx;
    logic                err_r, err_nx;

    logic [RATE_W-1:0]   rate;
    logic [CMP_W-1:0]    rate_x, ammo_x;
    logic [AMMO_W-1:0]   shot_left;
    logic [AMMO_W:0]     refill_sum;
    logic [AMMO_W-1:0]   refill;
    logic                auto_rl;

    assign rate   = rate_in[i*RATE_W +: RATE_W];
    assign rate_x = CMP_W'(rate);
    assign ammo_x = CMP_W'(ammo);

    // Shot saturates at zero; compare at the wider of the two widths.
    assign shot_left = (rate_x >= ammo_x) ? '0 : AMMO_W'(ammo_x - rate_x);

    assign refill_sum = {1'b0, ammo} + {1'b0, amt};
    assign refill     = (refill_sum > {1'b0, cap}) ? cap : refill_sum[AMMO_W-1:0];

`ifdef AUTO_RELOAD_EN
    assign auto_rl = (shot_left == '0);
`else
    assign auto_rl = 1'b0;
`endif

    always_comb begin
      state_nx = state;
      ammo_nx  = ammo;
      cap_nx   = cap;
      amt_nx   = amt;
      timer_nx = timer;
      err_nx   = 1'b0;

      unique case (state)
        ST_READY: begin
          if (reload_req[i]) begin
            state_nx = ST_RELOADING;
            timer_nx = T_RELOAD;
            amt_nx   = reload_amt;
            err_nx   = fire[i];
          end else if (fire[i]) begin
            if (!mode_ok || (ammo == '0)) begin
              err_nx = 1'b1;
            end else begin
              ammo_nx = shot_left;
              if (auto_rl) begin
                state_nx = ST_RELOADING;
                timer_nx = T_RELOAD;
                amt_nx   = cap;
              end else if (COOLDOWN_CYC > 0) begin
                state_nx = ST_COOLDOWN;
                timer_nx = T_COOL;
              end
            end
          end
        end

        ST_COOLDOWN: begin
          if (timer == T_ONE) begin
            state_nx = ST_READY;
            timer_nx = '0;
          end else begin
            timer_nx = timer - T_ONE;
          end
        end

        ST_RELOADING: begin
          err_nx = fire[i];
          if (timer == T_ONE) begin
            ammo_nx  = refill;
            state_nx = ST_READY;
            timer_nx = '0;
            amt_nx   = '0;
          end else begin
            timer_nx = timer - T_ONE;
          end
        end

        default: begin
          state_nx = ST_READY;
          timer_nx = '0;
        end
      endcase

      // Capacity change clamps whatever the FSM produced this cycle.
      if (cap_load[i]) begin
        cap_nx = cap_in;
        if (ammo_nx > cap_in) ammo_nx = cap_in;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= ST_READY;
        ammo  <= '0;
        cap   <= CAP_RST;
        amt   <= '0;
        timer <= '0;
        err_r <= 1'b0;
      end else begin
        state <= state_nx;
        ammo  <= ammo_nx;
        cap   <= cap_nx;
        amt   <= amt_nx;
        timer <= timer_nx;
        err_r <= err_nx;
      end
    end

    assign ammo_out[i*AMMO_W +: AMMO_W] = ammo;
    assign empty[i] = (ammo == '0);
    assign busy[i]  = (state != ST_READY);
    assign err[i]   = err_r;
  end

endmodule
`default_nettype wire
